instruction_fetch_unit: RTL
===========================

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset; SHALL be word aligned.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately on assertion.
REQ-004 program_counter  output  32  fetch address driven to instruction memory, equal to internal fetch_pc.
REQ-005 instruction_in  input  32  instruction word returned combinationally by memory for program_counter in the same cycle.
REQ-006 redirect_valid  input  1  one-cycle request to restart fetch at redirect_pc (branch/jump/trap).
REQ-007 redirect_pc  input  32  new fetch address, sampled when redirect_valid=1.
REQ-008 instr_valid  output  1  head of prefetch queue holds a valid instruction.
REQ-009 instr_ready  input  1  decode stage accepts the head entry this cycle.
REQ-010 instr_out  output  32  instruction word at queue head.
REQ-011 instr_pc  output  32  fetch address of instr_out.
REQ-012 fetch_fault  output  1  sticky misaligned-redirect flag (see Configuration).

Function
REQ-013 Unit SHALL hold a 2-entry FIFO prefetch queue of {pc, instruction} pairs plus a fetch_pc register.
REQ-014 Pop SHALL occur when instr_valid=1 and instr_ready=1; head advances on that edge.
REQ-015 Push SHALL occur in any cycle with no redirect and either count<2 or a same-cycle pop; pushed entry = {fetch_pc, instruction_in}.
REQ-016 On push, fetch_pc SHALL advance by 4, modulo 2^32 (32'hFFFF_FFFC wraps to 32'h0000_0000).
REQ-017 Full queue with no pop: no push, fetch_pc and program_counter held.
REQ-018 Simultaneous push and pop at count=2 SHALL keep count=2 with correct FIFO order.
REQ-019 instr_valid SHALL be 1 exactly when count>0; instr_out/instr_pc SHALL be the head entry; when count=0 both SHALL read 32'h0.
REQ-020 Redirect at cycle N: queue flushed (count=0), any pop at N discarded with no side effect, no push at N, fetch_pc=redirect_pc at N+1.
REQ-021 After redirect at N, first new entry pushed at N+1, instr_valid=1 with instr_pc=redirect_pc at N+2.
REQ-022 redirect_valid SHALL take priority over push and pop in the same cycle.
REQ-023 Redirect every cycle SHALL keep instr_valid=0 continuously.
REQ-024 Queue SHALL never overflow or underflow; count SHALL stay within 0..2.

Reset
REQ-025 On reset assertion: fetch_pc=RESET_PC, count=0, instr_valid=0, instr_out=0, instr_pc=0, fetch_fault=0, queue pointers 0.
REQ-026 First cycle after reset deassertion SHALL push {RESET_PC, instruction_in}; instr_valid=1 on the following cycle.
REQ-027 Reset mid-operation SHALL discard queued entries and any pending redirect.

Configuration
REQ-028 Macro FETCH_MISALIGN_TRAP_EN defined: redirect with redirect_pc[1:0]!=0 SHALL flush the queue, set fetch_fault=1 (sticky), and halt pushes until reset or an aligned redirect, which clears fetch_fault and resumes fetch.
REQ-029 Macro undefined: redirect_pc[1:0] SHALL be forced to 2'b00, fetch SHALL continue normally, fetch_fault tied 0.

Verification
REQ-030 Reset release, instr_ready=1 constantly, memory returning pc-tagged words -> instr_pc sequence 0,4,8,12 on consecutive cycles from cycle 2, one per cycle.
REQ-031 instr_ready=0 for 5 cycles -> count saturates at 2, program_counter frozen at 8, entries pc 0 and 4 then delivered in order when ready rises.
REQ-032 Redirect to 32'h0000_0040 while queue full and instr_ready=1 -> no pop consumed, instr_valid=0 next cycle, instr_pc=32'h40 two cycles after redirect.
REQ-033 Redirect to 32'hFFFF_FFF8, free-running -> instr_pc FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
REQ-034 Redirect to 32'h0000_0042: with FETCH_MISALIGN_TRAP_EN -> fetch_fault=1, instr_valid stays 0 until aligned redirect to 32'h44 clears it; without macro -> instr_pc=32'h40, fetch_fault=0.
REQ-035 Reset asserted asynchronously mid-cycle with count=2 -> instr_valid=0 and program_counter=RESET_PC immediately, before next clock edge.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: fetch_pc register feeding a 2-entry {pc, instruction}
// prefetch FIFO toward decode. Redirects flush the queue and restart fetch.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN. When it is defined, a misaligned
// redirect raises a sticky fetch_fault and halts fetch. When it is undefined,
// the low two bits of redirect_pc are forced to zero.
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] program_counter,
   input  logic [31:0] instruction_in,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr_out,
   output logic [31:0] instr_pc,
   output logic        fetch_fault
);

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   fetch_entry_t q [2];
   logic         rd_ptr;
   logic         wr_ptr;
   logic [1:0]   count;
   logic [31:0]  fetch_pc;
   logic         fault_q;
   logic         pop;
   logic         push;
   logic [31:0]  redirect_target;
   logic         redirect_bad;

`ifdef FETCH_MISALIGN_TRAP_EN
   // Keep the raw target; a misaligned target parks the unit in fault.
   assign redirect_target = redirect_pc;
   assign redirect_bad    = (redirect_pc[1:0] != 2'b00);
`else
   // Silently word-align the target; the fault never fires.
   assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
   assign redirect_bad    = 1'b0;
`endif

   // A redirect wins over everything. A pop in the same cycle is dropped,
   // and no push happens in that cycle.
   assign pop  = instr_valid & instr_ready & ~redirect_valid;
   assign push = ~redirect_valid & ~fault_q & ((count != 2'd2) | pop);

   assign program_counter = fetch_pc;
   assign instr_valid     = (count != 2'd0);
   assign instr_out       = instr_valid ? q[rd_ptr].instr : 32'h0;
   assign instr_pc        = instr_valid ? q[rd_ptr].pc    : 32'h0;
   assign fetch_fault     = fault_q;

   // Fetch PC, queue pointers/occupancy and fault flag; the redirect flushes the queue.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc <= RESET_PC;
         count    <= 2'd0;
         rd_ptr   <= 1'b0;
         wr_ptr   <= 1'b0;
         fault_q  <= 1'b0;
      end else if (redirect_valid) begin
         fetch_pc <= redirect_target;
         count    <= 2'd0;
         rd_ptr   <= 1'b0;
         wr_ptr   <= 1'b0;
         fault_q  <= redirect_bad;
      end else begin
         if (push) begin
            fetch_pc <= fetch_pc + 32'd4;
            wr_ptr   <= ~wr_ptr;
         end
         if (pop)
            rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end

   // Queue storage: capture the memory word for the current fetch address.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 2; i++)
            q[i] <= '0;
      end else if (push) begin
         q[wr_ptr] <= '{pc: fetch_pc, instr: instruction_in};
      end
   end

endmodule
